score_display_ctrl: RTL

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: converts an 8-bit score to three BCD digits with a
// sequential double-dabble engine and multiplexes them onto a three-digit
// seven-segment display with leading-zero blanking.
module score_display_ctrl #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       score_valid,
    input  logic [7:0] score,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t        state_q, state_d;
    logic [19:0]   shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic [7:0]    pend_score_q, pend_score_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [CW-1:0] refresh_q, refresh_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    // Active-high gfedcba pattern; non-decimal nibbles show nothing.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: eight convert cycles, one load cycle, chain if more work waits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (score_valid) state_d = CONVERT;
            CONVERT: if (cnt_q == 3'd7) state_d = LOAD;
            LOAD:    state_d = (score_valid || pend_valid_q) ? CONVERT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Converter datapath, pending slot and display registers.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_score_d = pend_score_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        case (state_q)
            IDLE: begin
                if (score_valid) begin
                    shift_d = {12'b0, score};
                    cnt_d   = 3'd0;
                end
            end
            CONVERT: begin
                shift_d = dabble_step(shift_q);
                cnt_d   = cnt_q + 3'd1;
                if (score_valid) begin
                    pend_valid_d = 1'b1;
                    pend_score_d = score;
                end
            end
            LOAD: begin
                hund_d = shift_q[19:16];
                tens_d = shift_q[15:12];
                ones_d = shift_q[11:8];
                // A strobe arriving in this very cycle is newer than anything pending.
                if (score_valid) begin
                    shift_d      = {12'b0, score};
                    cnt_d        = 3'd0;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    shift_d      = {12'b0, pend_score_q};
                    cnt_d        = 3'd0;
                    pend_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Refresh divider and digit scan index, free-running.
    always_comb begin
        refresh_d = refresh_q + CW'(1);
        digit_d   = digit_q;
        if (refresh_q == REF_MAX) begin
            refresh_d = '0;
            digit_d   = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end
    end

    // Next registered segment/anode values with leading-zero blanking.
    always_comb begin
        logic [6:0] pattern;
        pattern = 7'b0000000;
        an_d    = 3'b111;
        case (digit_q)
            2'd0: begin
                pattern = decode(ones_q);
                an_d    = 3'b110;
            end
            2'd1: begin
                if (!(hund_q == 4'd0 && tens_q == 4'd0)) pattern = decode(tens_q);
                an_d = 3'b101;
            end
            2'd2: begin
                if (hund_q != 4'd0) pattern = decode(hund_q);
                an_d = 3'b011;
            end
            default: ;
        endcase
        seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end

    // All state flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_score_q <= '0;
            hund_q       <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            refresh_q    <= '0;
            digit_q      <= '0;
            seg_q        <= SEG_RESET;
            an_q         <= 3'b110;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_score_q <= pend_score_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            refresh_q    <= refresh_d;
            digit_q      <= digit_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
